wb_commit: RTL and testbench

WB_COMMIT -- requirements
Module: wb_commit

---
 rtl/wb_commit_if.sv | 34 +++
 rtl/wb_commit.sv | 76 +++++++
 tb/tb_wb_commit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/wb_commit_if.sv
// Write-back commit bus: the MEM/WB-stage write ports, the two GPR read ports
// and the architectural HI/LO/LLbit views.
interface wb_commit_if;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        flush;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;

    modport master (
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, flush, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, LLbit_o
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, flush, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, hi_o, lo_o, LLbit_o
    );
endinterface

// File: rtl/wb_commit.sv
// Architectural state commit: 32x32 GPR file with write-through read ports,
// HI/LO pair and the LL/SC link bit.
module wb_commit (
    input  logic        clk,
    input  logic        rst,
    wb_commit_if.slave  bus
);
    logic [31:0] r_gpr [0:31];
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_llbit;

    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic        w_llbit;

    // A write in flight to the addressed register wins over the stored copy.
    function automatic logic [31:0] read_port(
        input logic        rst_i,
        input logic        re,
        input logic [4:0]  addr,
        input logic        wreg,
        input logic [4:0]  wd,
        input logic [31:0] wdata,
        input logic [31:0] stored
    );
        logic [31:0] val;
        val = 32'h0;
        if (rst_i || !re || addr == 5'd0)
            val = 32'h0;
        else if (wreg && wd == addr)
            val = wdata;
        else
            val = stored;
        return val;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                r_gpr[i] <= 32'h0;
            r_hi    <= 32'h0;
            r_lo    <= 32'h0;
            r_llbit <= 1'b0;
        end else begin
            if (bus.wb_wreg && bus.wb_wd != 5'd0)
                r_gpr[bus.wb_wd] <= bus.wb_wdata;
            if (bus.wb_whilo) begin
                r_hi <= bus.wb_hi;
                r_lo <= bus.wb_lo;
            end
            if (bus.flush)
                r_llbit <= 1'b0;
            else if (bus.wb_LLbit_we)
                r_llbit <= bus.wb_LLbit_value;
        end
    end

    always_comb begin
        w_rd1 = read_port(rst, bus.re1, bus.raddr1, bus.wb_wreg, bus.wb_wd,
                          bus.wb_wdata, r_gpr[bus.raddr1]);
        w_rd2 = read_port(rst, bus.re2, bus.raddr2, bus.wb_wreg, bus.wb_wd,
                          bus.wb_wdata, r_gpr[bus.raddr2]);
        w_llbit = r_llbit;
        if (rst || bus.flush)
            w_llbit = 1'b0;
        else if (bus.wb_LLbit_we)
            w_llbit = bus.wb_LLbit_value;
    end

    assign bus.rdata1  = w_rd1;
    assign bus.rdata2  = w_rd2;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;
    assign bus.LLbit_o = w_llbit;
endmodule

// File: tb/tb_wb_commit.sv
// Directed, table-driven bench for wb_commit: each record drives one cycle and
// checks the outputs seen before that cycle's commit edge.
module tb_wb_commit;
    logic clk;
    logic rst;
    wb_commit_if bus ();

    wb_commit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llval;
        logic        flush;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic        chkhl;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_ll;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic drive(input vec_t v);
        rst                = v.rst;
        bus.wb_wreg        = v.wreg;
        bus.wb_wd          = v.wd;
        bus.wb_wdata       = v.wdata;
        bus.wb_whilo       = v.whilo;
        bus.wb_hi          = v.hi;
        bus.wb_lo          = v.lo;
        bus.wb_LLbit_we    = v.llwe;
        bus.wb_LLbit_value = v.llval;
        bus.flush          = v.flush;
        bus.re1            = v.re1;
        bus.raddr1         = v.ra1;
        bus.re2            = v.re2;
        bus.raddr2         = v.ra2;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        n_vec++;
        chk("rdata1", idx, bus.rdata1, v.e_rd1);
        chk("rdata2", idx, bus.rdata2, v.e_rd2);
        chk("LLbit_o", idx, {31'h0, bus.LLbit_o}, {31'h0, v.e_ll});
        if (v.chkhl) begin
            chk("hi_o", idx, bus.hi_o, v.e_hi);
            chk("lo_o", idx, bus.lo_o, v.e_lo);
        end
    endtask

    vec_t idle;

    initial begin
        idle = '{0,0,5'd0,32'h0,0,32'h0,32'h0,0,0,0,0,5'd0,0,5'd0,1,32'h0,32'h0,0,32'h0,32'h0};
        drive(idle);
        rst = 1'b1;

        //          rst wr wd     wdata         hl hi            lo            lwe lv fl re1 ra1    re2 ra2    ck e_rd1         e_rd2         ell e_hi          e_lo
        tbl.push_back('{1, 1, 5'd5, 32'h0000_0055, 1, 32'h1,        32'h1,        1, 1, 0, 1, 5'd5,  1, 5'd5,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{1, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd5,  1, 5'd1,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 1, 5'd5, 32'hDEADBEEF,  0, 32'h0,        32'h0,        0, 0, 0, 0, 5'd5,  0, 5'd5,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd5,  0, 5'd5,  1, 32'hDEADBEEF, 32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 1, 5'd7, 32'h12345678,  0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd7,  1, 5'd7,  1, 32'h12345678, 32'h12345678, 0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd7,  1, 5'd5,  1, 32'h12345678, 32'hDEADBEEF, 0, 32'h0,        32'h0});
        tbl.push_back('{0, 1, 5'd0, 32'hFFFFFFFF,  0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd0,  1, 5'd0,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd0,  1, 5'd7,  1, 32'h0,        32'h12345678, 0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         1, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h11111111, 32'h22222222, 0, 0, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{0, 0, 5'd5, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd5,  0, 5'd0,  1, 32'hDEADBEEF, 32'h0,        0, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd5,  0, 5'd0,  1, 32'hDEADBEEF, 32'h0,        0, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        1, 1, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        1, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        1, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        1, 1, 1, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{0, 1, 5'd3, 32'h00000001,  1, 32'h00000002, 32'h00000003, 1, 1, 0, 1, 5'd3,  0, 5'd0,  1, 32'h00000001, 32'h0,        1, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{1, 1, 5'd4, 32'h00000044,  1, 32'h9,        32'h9,        1, 1, 0, 1, 5'd3,  1, 5'd4,  1, 32'h0,        32'h0,        0, 32'h00000002, 32'h00000003});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd3,  1, 5'd4,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd5,  1, 5'd7,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 1, 5'd31, 32'hCAFEF00D, 0, 32'h0,        32'h0,        1, 1, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        1, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 1, 5'd31, 0, 5'd31, 1, 32'hCAFEF00D, 32'h0,        1, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 1, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        1, 1, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        1, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        1, 0, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});
        tbl.push_back('{0, 0, 5'd0, 32'h0,         0, 32'h0,        32'h0,        0, 0, 0, 0, 5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 32'h0,        32'h0});

        foreach (tbl[i]) apply(tbl[i], i);

        // Back-to-back writes to one register: the in-flight value must beat the stored one.
        begin
            vec_t v;
            v = idle; v.wreg = 1; v.wd = 5'd9; v.wdata = 32'h1111_0001;
            apply(v, 100);
            v = idle; v.wreg = 1; v.wd = 5'd9; v.wdata = 32'h2222_0002;
            v.re1 = 1; v.ra1 = 5'd9; v.re2 = 1; v.ra2 = 5'd9;
            v.e_rd1 = 32'h2222_0002; v.e_rd2 = 32'h2222_0002;
            apply(v, 101);
            v = idle; v.re1 = 1; v.ra1 = 5'd9; v.re2 = 1; v.ra2 = 5'd10;
            v.e_rd1 = 32'h2222_0002;
            apply(v, 102);
        end

        // Disabled ports with garbage data must leave state untouched.
        begin
            vec_t v;
            v = idle; v.wd = 5'd9; v.wdata = 32'hFFFF_FFFF; v.hi = 32'hFFFF_FFFF; v.lo = 32'hFFFF_FFFF;
            v.llval = 1; v.re1 = 1; v.ra1 = 5'd9; v.re2 = 0; v.ra2 = 5'd9;
            v.e_rd1 = 32'h2222_0002;
            apply(v, 103);
            v = idle; v.re1 = 1; v.ra1 = 5'd9; v.e_rd1 = 32'h2222_0002;
            apply(v, 104);
        end

        // Reset held for two cycles, then the first edge with rst low commits again.
        begin
            vec_t v;
            v = idle; v.rst = 1; v.wreg = 1; v.wd = 5'd9; v.wdata = 32'h5;
            v.re1 = 1; v.ra1 = 5'd9;
            apply(v, 105);
            v = idle; v.rst = 1; v.re1 = 1; v.ra1 = 5'd9;
            apply(v, 106);
            v = idle; v.wreg = 1; v.wd = 5'd12; v.wdata = 32'h0BAD_F00D; v.whilo = 1;
            v.hi = 32'h7; v.lo = 32'h8; v.re1 = 1; v.ra1 = 5'd9;
            apply(v, 107);
            v = idle; v.re1 = 1; v.ra1 = 5'd12; v.re2 = 1; v.ra2 = 5'd9;
            v.e_rd1 = 32'h0BAD_F00D; v.e_hi = 32'h7; v.e_lo = 32'h8;
            apply(v, 108);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
